// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg : shared Y86-64 status codes, icodes and register indices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  typedef enum logic [3:0] {
    STAT_AOK = 4'b1000,
    STAT_HLT = 4'b0100,
    STAT_ADR = 4'b0010,
    STAT_INS = 4'b0001
  } stat_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NREGS = 15;

  function automatic logic is_aok(input logic [3:0] s);
    return s == STAT_AOK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_pipe_if.sv
// ---------------------------------------------------------------------------
// writeback_pipe_if : memory-stage inputs, decode read ports and W-stage view
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface writeback_pipe_if #(
  parameter int WORD_W = 64
);
  logic [3:0]        m_stat;
  logic [3:0]        m_icode;
  logic [WORD_W-1:0] m_valE;
  logic [WORD_W-1:0] m_valM;
  logic [3:0]        m_dstE;
  logic [3:0]        m_dstM;
  logic              W_stall;
  logic              W_bubble;
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;
  logic [WORD_W-1:0] d_rvalA;
  logic [WORD_W-1:0] d_rvalB;
  logic [3:0]        W_stat;
  logic [3:0]        W_icode;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;
  logic [WORD_W-1:0] W_valE;
  logic [WORD_W-1:0] W_valM;
  logic [3:0]        Stat;
  logic              halted;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
    output W_stall, W_bubble, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, W_stat, W_icode, W_dstE, W_dstM,
    input  W_valE, W_valM, Stat, halted
  );

  modport slave (
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
    input  W_stall, W_bubble, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, W_stat, W_icode, W_dstE, W_dstM,
    output W_valE, W_valM, Stat, halted
  );
endinterface

`default_nettype wire

// File: rtl/regfile_y86.sv
// ---------------------------------------------------------------------------
// regfile_y86 : 15-entry register file, 2 comb read ports, 2 write ports
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_y86
  import y86_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [3:0]        i_dst_e,
  input  logic [WORD_W-1:0] i_val_e,
  input  logic [3:0]        i_dst_m,
  input  logic [WORD_W-1:0] i_val_m,
  input  logic [3:0]        i_src_a,
  input  logic [3:0]        i_src_b,
  output logic [WORD_W-1:0] o_rval_a,
  output logic [WORD_W-1:0] o_rval_b
);

  logic [WORD_W-1:0] r_regs [NREGS];

  // valM port is written last so it overrides valE on a shared destination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      if (i_dst_e != RNONE) begin
        r_regs[i_dst_e] <= i_val_e;
      end
      if (i_dst_m != RNONE) begin
        r_regs[i_dst_m] <= i_val_m;
      end
    end
  end

  assign o_rval_a = (i_src_a == RNONE) ? '0 : r_regs[i_src_a];
  assign o_rval_b = (i_src_b == RNONE) ? '0 : r_regs[i_src_b];

endmodule

`default_nettype wire

// File: rtl/writeback_pipe.sv
// ---------------------------------------------------------------------------
// writeback_pipe : Y86-64 W register, register file write, status/halt
// Optional macro WB_RETIRE_CNT_EN adds the 64-bit retired counter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module writeback_pipe
  import y86_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic               clk,
  input  logic               rst,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]        retired,
`endif
  writeback_pipe_if.slave    bus
);

  logic [3:0]        r_W_stat;
  logic [3:0]        r_W_icode;
  logic [3:0]        r_W_dstE;
  logic [3:0]        r_W_dstM;
  logic [WORD_W-1:0] r_W_valE;
  logic [WORD_W-1:0] r_W_valM;
  logic              r_halted;
  logic              w_commit;
  logic              w_hold;

  assign w_commit = is_aok(r_W_stat) && !r_halted;
  // A faulting W entry is never overwritten, so Stat keeps the fault code
  assign w_hold   = r_halted || !is_aok(r_W_stat) || bus.W_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_W_stat  <= STAT_AOK;
      r_W_icode <= I_NOP;
      r_W_dstE  <= RNONE;
      r_W_dstM  <= RNONE;
      r_W_valE  <= '0;
      r_W_valM  <= '0;
    end else if (!w_hold) begin
      if (bus.W_bubble) begin
        r_W_stat  <= STAT_AOK;
        r_W_icode <= I_NOP;
        r_W_dstE  <= RNONE;
        r_W_dstM  <= RNONE;
        r_W_valE  <= '0;
        r_W_valM  <= '0;
      end else begin
        r_W_stat  <= bus.m_stat;
        r_W_icode <= bus.m_icode;
        r_W_dstE  <= bus.m_dstE;
        r_W_dstM  <= bus.m_dstM;
        r_W_valE  <= bus.m_valE;
        r_W_valM  <= bus.m_valM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (!is_aok(r_W_stat)) begin
      r_halted <= 1'b1;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_commit && (r_W_icode != I_NOP)) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  assign retired = r_retired;
`endif

  regfile_y86 #(
    .WORD_W (WORD_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_commit),
    .i_dst_e  (r_W_dstE),
    .i_val_e  (r_W_valE),
    .i_dst_m  (r_W_dstM),
    .i_val_m  (r_W_valM),
    .i_src_a  (bus.d_srcA),
    .i_src_b  (bus.d_srcB),
    .o_rval_a (bus.d_rvalA),
    .o_rval_b (bus.d_rvalB)
  );

  assign bus.W_stat  = r_W_stat;
  assign bus.W_icode = r_W_icode;
  assign bus.W_dstE  = r_W_dstE;
  assign bus.W_dstM  = r_W_dstM;
  assign bus.W_valE  = r_W_valE;
  assign bus.W_valM  = r_W_valM;
  assign bus.Stat    = r_W_stat;
  assign bus.halted  = r_halted;

endmodule

`default_nettype wire
